// File: rtl/ptp_pkg.sv
// Shared PTP definitions: register offsets, frame byte offsets, rx FSM states and STAT bit positions.
// Imported by both the Delay_Req generator and the rx parser.
package ptp_pkg;

  localparam logic [31:0] REG_CTRL = 32'h00;
  localparam logic [31:0] REG_STAT = 32'h04;
  localparam logic [31:0] REG_INFO = 32'h08;
  localparam logic [31:0] REG_TSSH = 32'h0C;
  localparam logic [31:0] REG_TSSL = 32'h10;
  localparam logic [31:0] REG_TSNS = 32'h14;
  localparam logic [31:0] REG_FCNT = 32'h18;

  localparam logic [5:0] OFF_MSGTYPE   = 6'd0;
  localparam logic [5:0] OFF_VERSION   = 6'd1;
  localparam logic [5:0] OFF_SEQ_HI    = 6'd30;
  localparam logic [5:0] OFF_TS_SEC_HI = 6'd34;
  localparam logic [5:0] OFF_TS_NS_HI  = 6'd40;
  localparam logic [5:0] OFF_LAST      = 6'd43;

  localparam int STAT_RX_VALID  = 0;
  localparam int STAT_ERR_SHORT = 1;
  localparam int STAT_ERR_LONG  = 2;
  localparam int STAT_ERR_VER   = 3;
  localparam int STAT_OVERRUN   = 4;
  localparam int STAT_W         = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic [3:0]  msg_type;
    logic [15:0] seq_id;
    logic [47:0] sec;
    logic [31:0] ns;
  } ptp_rec_t;

endpackage

// File: rtl/ptp_rx_parser_if.sv
// Wishbone slave, AXI-Stream byte sink and interrupt of the PTP rx parser, bundled for port hookup.
interface ptp_rx_parser_if;

  logic [31:0] wbs_addr_i;
  logic [31:0] wbs_data_i;
  logic [31:0] wbs_data_o;
  logic        wbs_we_i;
  logic        wbs_stb_i;
  logic        wbs_ack_o;
  logic [7:0]  axis_tdata_i;
  logic        axis_tvalid_i;
  logic        axis_tready_o;
  logic        axis_tlast_i;
  logic        irq_o;

  modport slave (
    input  wbs_addr_i, wbs_data_i, wbs_we_i, wbs_stb_i,
    input  axis_tdata_i, axis_tvalid_i, axis_tlast_i,
    output wbs_data_o, wbs_ack_o, axis_tready_o, irq_o
  );

  modport master (
    output wbs_addr_i, wbs_data_i, wbs_we_i, wbs_stb_i,
    output axis_tdata_i, axis_tvalid_i, axis_tlast_i,
    input  wbs_data_o, wbs_ack_o, axis_tready_o, irq_o
  );

endinterface

// File: rtl/ptp_wb_regs.sv
// Wishbone register bank of the rx parser: decode, one-shot ack, CTRL, W1C STAT and the committed frame record.
// Ack and read data land one cycle after stb with no back-to-back acks; status/commit events apply on the flagged edge.
module ptp_wb_regs
  import ptp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  input  logic        i_commit,
  input  ptp_rec_t    i_commit_rec,
  input  logic        i_set_short,
  input  logic        i_set_long,
  input  logic        i_set_ver,
  output logic        o_en,
  output logic        o_irq
);

  logic [1:0]        r_ctrl;
  logic [STAT_W-1:0] r_stat;
  ptp_rec_t          r_rec;
  logic [31:0]       r_fcnt;
  logic [31:0]       r_rdata;
  logic              r_ack;

  logic              w_access;
  logic              w_wr;
  logic              w_rd;
  logic [31:0]       w_rdata_nxt;
  logic [STAT_W-1:0] w_stat_set;
  logic [STAT_W-1:0] w_stat_clr;
  logic              w_unused_ok;

  // A held strobe is served every other cycle because the pending ack masks it.
  assign w_access = i_wb_stb & ~r_ack;
  assign w_wr     = w_access & i_wb_we;
  assign w_rd     = w_access & ~i_wb_we;

  always_comb begin
    w_rdata_nxt = '0;
    case (i_wb_addr)
      BASE_ADDR + REG_CTRL: w_rdata_nxt = {30'd0, r_ctrl};
      BASE_ADDR + REG_STAT: w_rdata_nxt = {{(32 - STAT_W){1'b0}}, r_stat};
      BASE_ADDR + REG_INFO: w_rdata_nxt = {r_rec.msg_type, 12'h000, r_rec.seq_id};
      BASE_ADDR + REG_TSSH: w_rdata_nxt = {16'h0000, r_rec.sec[47:32]};
      BASE_ADDR + REG_TSSL: w_rdata_nxt = r_rec.sec[31:0];
      BASE_ADDR + REG_TSNS: w_rdata_nxt = r_rec.ns;
      BASE_ADDR + REG_FCNT: w_rdata_nxt = r_fcnt;
      default:              w_rdata_nxt = '0;
    endcase
  end

  always_comb begin
    w_stat_set                 = '0;
    w_stat_set[STAT_RX_VALID]  = i_commit;
    w_stat_set[STAT_ERR_SHORT] = i_set_short;
    w_stat_set[STAT_ERR_LONG]  = i_set_long;
    w_stat_set[STAT_ERR_VER]   = i_set_ver;
    w_stat_set[STAT_OVERRUN]   = i_commit & r_stat[STAT_RX_VALID];
  end

  assign w_stat_clr = (w_wr && (i_wb_addr == BASE_ADDR + REG_STAT)) ? i_wb_data[STAT_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl  <= '0;
      r_stat  <= '0;
      r_rec   <= '0;
      r_fcnt  <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= w_access;
      if (w_rd) begin
        r_rdata <= w_rdata_nxt;
      end
      if (w_wr && (i_wb_addr == BASE_ADDR + REG_CTRL)) begin
        r_ctrl <= i_wb_data[1:0];
      end
      // Clear first, then OR the set events so a same-cycle set survives the W1C.
      r_stat <= (r_stat & ~w_stat_clr) | w_stat_set;
      if (i_commit) begin
        r_rec  <= i_commit_rec;
        r_fcnt <= r_fcnt + 32'd1;
      end
    end
  end

  assign o_wb_data   = r_rdata;
  assign o_wb_ack    = r_ack;
  assign o_en        = r_ctrl[0];
  assign o_irq       = r_stat[STAT_RX_VALID] & r_ctrl[1];
  assign w_unused_ok = ^i_wb_data[31:STAT_W];

endmodule

// File: rtl/ptp_rx_parser.sv
// PTP rx parser: parses header + originTimestamp from a byte AXI-Stream and commits good frames to Wishbone registers.
// Commit happens on the edge that accepts the final byte; tready is high whenever rst is low, so the MAC never stalls.
module ptp_rx_parser
  import ptp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0200,
  parameter logic [3:0]  PTP_VERSION = 4'h2,
  parameter int          FRAME_BYTES = 44
) (
  input logic            clk,
  input logic            rst,
  ptp_rx_parser_if.slave bus
);

  localparam logic [5:0] LAST_IDX = 6'(FRAME_BYTES - 1);

  rx_state_t  r_state;
  rx_state_t  w_state_nxt;
  logic [5:0] r_byte_cnt;
  logic [5:0] w_byte_cnt_nxt;
  ptp_rec_t   r_shadow;
  ptp_rec_t   w_commit_rec;

  logic w_beat;
  logic w_en;
  logic w_ver_ok;
  logic w_commit;
  logic w_set_short;
  logic w_set_long;
  logic w_set_ver;

  assign bus.axis_tready_o = ~rst;
  assign w_beat            = bus.axis_tvalid_i & bus.axis_tready_o;
  assign w_ver_ok          = (bus.axis_tdata_i[3:0] == PTP_VERSION);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_cnt_nxt = r_byte_cnt;
    w_commit       = 1'b0;
    w_set_short    = 1'b0;
    w_set_long     = 1'b0;
    w_set_ver      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_beat) begin
          w_byte_cnt_nxt = 6'd1;
          if (!w_en) begin
            w_state_nxt = bus.axis_tlast_i ? ST_IDLE : ST_DROP;
          end else if (bus.axis_tlast_i) begin
            w_set_short = 1'b1;
          end else begin
            w_state_nxt = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (w_beat) begin
          w_byte_cnt_nxt = r_byte_cnt + 6'd1;
          if ((r_byte_cnt == OFF_VERSION) && !w_ver_ok) begin
            w_set_ver   = 1'b1;
            w_state_nxt = bus.axis_tlast_i ? ST_IDLE : ST_DROP;
          end else if (r_byte_cnt == LAST_IDX) begin
            if (bus.axis_tlast_i) begin
              w_commit    = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_set_long  = 1'b1;
              w_state_nxt = ST_DROP;
            end
          end else if (bus.axis_tlast_i) begin
            w_set_short = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (w_beat && bus.axis_tlast_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Multi-byte fields arrive MSB first, so each is a left shift that is exactly full after its last byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (w_beat) begin
      if ((r_state == ST_IDLE) && w_en) begin
        r_shadow.msg_type <= bus.axis_tdata_i[3:0];
      end else if (r_state == ST_RECV) begin
        if ((r_byte_cnt == OFF_SEQ_HI) || (r_byte_cnt == OFF_SEQ_HI + 6'd1)) begin
          r_shadow.seq_id <= {r_shadow.seq_id[7:0], bus.axis_tdata_i};
        end
        if ((r_byte_cnt >= OFF_TS_SEC_HI) && (r_byte_cnt < OFF_TS_NS_HI)) begin
          r_shadow.sec <= {r_shadow.sec[39:0], bus.axis_tdata_i};
        end
        if (r_byte_cnt >= OFF_TS_NS_HI) begin
          r_shadow.ns <= {r_shadow.ns[23:0], bus.axis_tdata_i};
        end
      end
    end
  end

  // The last nanosecond byte is still on the bus in the commit cycle.
  always_comb begin
    w_commit_rec    = r_shadow;
    w_commit_rec.ns = {r_shadow.ns[23:0], bus.axis_tdata_i};
  end

  ptp_wb_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk          (clk),
    .rst          (rst),
    .i_wb_addr    (bus.wbs_addr_i),
    .i_wb_data    (bus.wbs_data_i),
    .i_wb_we      (bus.wbs_we_i),
    .i_wb_stb     (bus.wbs_stb_i),
    .o_wb_data    (bus.wbs_data_o),
    .o_wb_ack     (bus.wbs_ack_o),
    .i_commit     (w_commit),
    .i_commit_rec (w_commit_rec),
    .i_set_short  (w_set_short),
    .i_set_long   (w_set_long),
    .i_set_ver    (w_set_ver),
    .o_en         (w_en),
    .o_irq        (bus.irq_o)
  );

endmodule

// File: tb/tb_ptp_rx_parser.sv
// Directed bench for ptp_rx_parser: byte-stream frames plus Wishbone register traffic, hand-computed expectations.
module tb_ptp_rx_parser;

  localparam logic [31:0] BASE   = 32'h0300_0200;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_INFO = BASE + 32'h08;
  localparam logic [31:0] A_TSSH = BASE + 32'h0C;
  localparam logic [31:0] A_TSSL = BASE + 32'h10;
  localparam logic [31:0] A_TSNS = BASE + 32'h14;
  localparam logic [31:0] A_FCNT = BASE + 32'h18;

  logic       clk = 1'b0;
  logic       rst;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] frm [64];

  ptp_rx_parser_if bus();

  ptp_rx_parser #(
    .BASE_ADDR   (BASE),
    .PTP_VERSION (4'h2),
    .FRAME_BYTES (44)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] data);
    bus.wbs_stb_i  = 1'b1;
    bus.wbs_we_i   = 1'b1;
    bus.wbs_addr_i = addr;
    bus.wbs_data_i = data;
    tick();
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus.wbs_stb_i  = 1'b1;
    bus.wbs_we_i   = 1'b0;
    bus.wbs_addr_i = addr;
    tick();
    d = bus.wbs_data_o;
    bus.wbs_stb_i = 1'b0;
    tick();
    check(tag, d, exp);
  endtask

  task automatic build(input logic [3:0] msg, input logic [3:0] ver, input logic [15:0] seq,
                       input logic [47:0] sec, input logic [31:0] ns);
    for (int i = 0; i < 64; i++) frm[i] = 8'hEE;
    frm[0]  = {4'h0, msg};
    frm[1]  = {4'h0, ver};
    frm[30] = seq[15:8];
    frm[31] = seq[7:0];
    for (int k = 0; k < 6; k++) frm[34 + k] = sec[47 - 8 * k -: 8];
    for (int k = 0; k < 4; k++) frm[40 + k] = ns[31 - 8 * k -: 8];
  endtask

  task automatic send(input int lo, input int hi, input bit last);
    for (int i = lo; i <= hi; i++) begin
      bus.axis_tvalid_i = 1'b1;
      bus.axis_tdata_i  = frm[i];
      bus.axis_tlast_i  = last && (i == hi);
      tick();
    end
    bus.axis_tvalid_i = 1'b0;
    bus.axis_tlast_i  = 1'b0;
  endtask

  initial begin
    bus.wbs_addr_i    = '0;
    bus.wbs_data_i    = '0;
    bus.wbs_we_i      = 1'b0;
    bus.wbs_stb_i     = 1'b0;
    bus.axis_tdata_i  = '0;
    bus.axis_tvalid_i = 1'b0;
    bus.axis_tlast_i  = 1'b0;
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_tready", {31'd0, bus.axis_tready_o}, 32'd0);
    check("rst_ack",    {31'd0, bus.wbs_ack_o},     32'd0);
    check("rst_rdata",  bus.wbs_data_o,             32'd0);
    check("rst_irq",    {31'd0, bus.irq_o},         32'd0);
    rst = 1'b0;
    tick();
    check("tready_up", {31'd0, bus.axis_tready_o}, 32'd1);
    rd_chk("rst_ctrl", A_CTRL, 32'd0);
    rd_chk("rst_stat", A_STAT, 32'd0);
    rd_chk("rst_fcnt", A_FCNT, 32'd0);

    // Good frame
    wb_write(A_CTRL, 32'h1);
    build(4'h1, 4'h2, 16'h1234, 48'h0000_0000_0005, 32'h1DCD_6500);
    send(0, 43, 1'b1);
    rd_chk("good_info", A_INFO, 32'h1000_1234);
    rd_chk("good_tssh", A_TSSH, 32'h0000_0000);
    rd_chk("good_tssl", A_TSSL, 32'h0000_0005);
    rd_chk("good_tsns", A_TSNS, 32'h1DCD_6500);
    rd_chk("good_stat", A_STAT, 32'h01);
    rd_chk("good_fcnt", A_FCNT, 32'd1);
    check("good_irq_masked", {31'd0, bus.irq_o}, 32'd0);

    // Short frame, then a good frame with wide seconds
    wb_write(A_STAT, 32'h1F);
    rd_chk("w1c_stat", A_STAT, 32'h00);
    send(0, 20, 1'b1);
    rd_chk("short_stat", A_STAT, 32'h02);
    rd_chk("short_info", A_INFO, 32'h1000_1234);
    rd_chk("short_fcnt", A_FCNT, 32'd1);
    build(4'h3, 4'h2, 16'hBEEF, 48'hABCD_0123_4567, 32'h0000_0042);
    send(0, 43, 1'b1);
    rd_chk("b_info", A_INFO, 32'h3000_BEEF);
    rd_chk("b_tssh", A_TSSH, 32'h0000_ABCD);
    rd_chk("b_tssl", A_TSSL, 32'h0123_4567);
    rd_chk("b_tsns", A_TSNS, 32'h0000_0042);
    rd_chk("b_stat", A_STAT, 32'h03);
    rd_chk("b_fcnt", A_FCNT, 32'd2);

    // Long frame, bad version, then a good frame proves the FSM is back in IDLE
    wb_write(A_STAT, 32'h1F);
    send(0, 49, 1'b1);
    rd_chk("long_stat", A_STAT, 32'h04);
    rd_chk("long_fcnt", A_FCNT, 32'd2);
    rd_chk("long_info", A_INFO, 32'h3000_BEEF);
    build(4'h1, 4'h1, 16'h9999, 48'h9, 32'h9);
    send(0, 43, 1'b1);
    rd_chk("ver_stat", A_STAT, 32'h0C);
    rd_chk("ver_fcnt", A_FCNT, 32'd2);
    build(4'h2, 4'h2, 16'h0007, 48'h1, 32'h3);
    send(0, 43, 1'b1);
    rd_chk("c_stat", A_STAT, 32'h0D);
    rd_chk("c_info", A_INFO, 32'h2000_0007);
    rd_chk("c_fcnt", A_FCNT, 32'd3);

    // Overrun, then W1C of rx_valid in the commit cycle of a third frame
    wb_write(A_STAT, 32'h1F);
    build(4'h4, 4'h2, 16'h1111, 48'h10, 32'h20);
    send(0, 43, 1'b1);
    rd_chk("d_stat", A_STAT, 32'h01);
    build(4'h5, 4'h2, 16'h2222, 48'h30, 32'h40);
    send(0, 43, 1'b1);
    rd_chk("ovr_stat", A_STAT, 32'h11);
    rd_chk("ovr_info", A_INFO, 32'h5000_2222);
    rd_chk("ovr_fcnt", A_FCNT, 32'd5);
    build(4'h6, 4'h2, 16'h3333, 48'h50, 32'h60);
    send(0, 42, 1'b0);
    bus.axis_tvalid_i = 1'b1;
    bus.axis_tdata_i  = frm[43];
    bus.axis_tlast_i  = 1'b1;
    bus.wbs_stb_i     = 1'b1;
    bus.wbs_we_i      = 1'b1;
    bus.wbs_addr_i    = A_STAT;
    bus.wbs_data_i    = 32'h1;
    tick();
    bus.axis_tvalid_i = 1'b0;
    bus.axis_tlast_i  = 1'b0;
    bus.wbs_stb_i     = 1'b0;
    bus.wbs_we_i      = 1'b0;
    tick();
    rd_chk("setwins_stat", A_STAT, 32'h11);
    rd_chk("setwins_info", A_INFO, 32'h6000_3333);
    rd_chk("setwins_tsns", A_TSNS, 32'h0000_0060);
    rd_chk("setwins_fcnt", A_FCNT, 32'd6);

    // Disabled frame, enable mid-frame, then irq
    wb_write(A_STAT, 32'h1F);
    wb_write(A_CTRL, 32'h0);
    build(4'h7, 4'h2, 16'h4444, 48'h1, 32'h1);
    send(0, 43, 1'b1);
    rd_chk("dis_stat", A_STAT, 32'h00);
    rd_chk("dis_fcnt", A_FCNT, 32'd6);
    build(4'h8, 4'h2, 16'h4545, 48'h2, 32'h2);
    send(0, 19, 1'b0);
    wb_write(A_CTRL, 32'h1);
    send(20, 43, 1'b1);
    rd_chk("midena_stat", A_STAT, 32'h00);
    rd_chk("midena_fcnt", A_FCNT, 32'd6);
    rd_chk("midena_info", A_INFO, 32'h6000_3333);
    wb_write(A_CTRL, 32'h3);
    build(4'h9, 4'h2, 16'h5555, 48'h70, 32'h80);
    send(0, 42, 1'b0);
    check("irq_pre_commit", {31'd0, bus.irq_o}, 32'd0);
    send(43, 43, 1'b1);
    check("irq_after_commit", {31'd0, bus.irq_o}, 32'd1);
    wb_write(A_STAT, 32'h01);
    check("irq_after_w1c", {31'd0, bus.irq_o}, 32'd0);
    rd_chk("irq_stat", A_STAT, 32'h00);

    // Read-only writes ignored; unmapped read returns 0 with a single-cycle ack
    wb_write(A_FCNT, 32'hFFFF_FFFF);
    wb_write(A_INFO, 32'h0);
    rd_chk("ro_fcnt", A_FCNT, 32'd7);
    rd_chk("ro_info", A_INFO, 32'h9000_5555);
    bus.wbs_stb_i  = 1'b1;
    bus.wbs_we_i   = 1'b0;
    bus.wbs_addr_i = BASE + 32'h20;
    tick();
    check("unmapped_ack",  {31'd0, bus.wbs_ack_o}, 32'd1);
    check("unmapped_data", bus.wbs_data_o,         32'd0);
    tick();
    check("no_b2b_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    bus.wbs_stb_i = 1'b0;
    tick();

    // Reset at byte 15; the tail is parsed as a fresh, short frame
    wb_write(A_CTRL, 32'h1);
    build(4'hA, 4'h2, 16'h6666, 48'h3, 32'h4);
    frm[16] = 8'h02;
    send(0, 14, 1'b0);
    bus.axis_tvalid_i = 1'b1;
    bus.axis_tdata_i  = frm[15];
    rst = 1'b1;
    tick();
    check("midrst_tready", {31'd0, bus.axis_tready_o}, 32'd0);
    check("midrst_ack",    {31'd0, bus.wbs_ack_o},     32'd0);
    check("midrst_rdata",  bus.wbs_data_o,             32'd0);
    tick();
    rst = 1'b0;
    bus.axis_tvalid_i = 1'b0;
    tick();
    rd_chk("postrst_ctrl", A_CTRL, 32'd0);
    rd_chk("postrst_stat", A_STAT, 32'd0);
    rd_chk("postrst_info", A_INFO, 32'd0);
    rd_chk("postrst_tssl", A_TSSL, 32'd0);
    rd_chk("postrst_fcnt", A_FCNT, 32'd0);
    wb_write(A_CTRL, 32'h1);
    send(15, 43, 1'b1);
    rd_chk("tail_stat", A_STAT, 32'h02);
    rd_chk("tail_fcnt", A_FCNT, 32'd0);
    rd_chk("tail_info", A_INFO, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
